// File: rtl/string_compare_engine_if.sv
// Paired word-FIFO read ports (A and B) feeding the compare engine.
// master: FIFO side drives data/valid; slave: engine drives ready (pop).
interface string_compare_engine_if;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;

  modport master (
    output a_data, a_valid, b_data, b_valid,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid,
    output a_ready, b_ready
  );
endinterface

// File: rtl/string_compare_engine.sv
// Pops paired words from FIFO A/B and compares up to `length` bytes.
// Ports: clk, reset, go, length, fifo (A/B pop ports), busy, done, equal,
// a_gt_b, mismatch_idx.
module string_compare_engine #(
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = $clog2(4*MAX_WORDS+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [LEN_W-1:0] length,
  string_compare_engine_if.slave fifo,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             a_gt_b,
  output logic [LEN_W-1:0] mismatch_idx
);

  typedef enum logic [1:0] {
    IDLE, FETCH, CMP, FIN
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN =
    LEN_W'(4*MAX_WORDS);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] off_q;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] len_clamp;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             found;
  logic             pop;
  logic             last;
  logic             hit;
  logic             hit_gt;
  logic [1:0]       hit_idx;

  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;

  // Both FIFOs pop together or not at all, so A and B stay word-aligned.
  assign pop = (state == FETCH) & fifo.a_valid & fifo.b_valid;
  assign fifo.a_ready = pop;
  assign fifo.b_ready = pop;

  // Bytes still to compare from the current word onward.
  assign rem  = len_q - off_q;
  assign last = rem <= LEN_W'(4);

  // Lowest-index mismatching byte within the held word; bytes past the
  // end of the string are masked off. Descending scan leaves the lowest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_gt  = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (LEN_W'(j) < rem &&
          a_q[8*(3-j) +: 8] != b_q[8*(3-j) +: 8]) begin
        hit     = 1'b1;
        hit_idx = 2'(j);
        hit_gt  = a_q[8*(3-j) +: 8] > b_q[8*(3-j) +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      off_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      found        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      a_gt_b       <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            len_q        <= len_clamp;
            off_q        <= '0;
            found        <= 1'b0;
            equal        <= 1'b0;
            a_gt_b       <= 1'b0;
            mismatch_idx <= '0;
            done         <= 1'b0;
            if (len_clamp == '0) begin
              state <= FIN;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (pop) begin
            a_q   <= fifo.a_data;
            b_q   <= fifo.b_data;
            state <= CMP;
          end
        end
        CMP: begin
          // Only the first mismatch of the whole string is kept.
          if (hit && !found) begin
            found        <= 1'b1;
            mismatch_idx <= off_q + LEN_W'(hit_idx);
            a_gt_b       <= hit_gt;
          end
          // Keep draining after a mismatch so the FIFOs end aligned.
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
          end else begin
            off_q <= off_q + LEN_W'(4);
            state <= FETCH;
          end
        end
        FIN: begin
          done  <= 1'b1;
          equal <= !found;
          if (!found) mismatch_idx <= len_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_string_compare_engine.sv
// Randomised bench for string_compare_engine with a byte-string model.
// Drives FIFO A/B from queues and checks outputs every cycle.
module tb_string_compare_engine;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [LW-1:0] length = '0;
  logic          busy;
  logic          done;
  logic          equal;
  logic          a_gt_b;
  logic [LW-1:0] mismatch_idx;

  string_compare_engine_if ifc();

  string_compare_engine dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .length       (length),
    .fifo         (ifc),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .a_gt_b       (a_gt_b),
    .mismatch_idx (mismatch_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit a_en = 1'b1;
  bit b_en = 1'b1;
  int pops_a = 0;
  int pops_b = 0;

  logic [31:0] wa[16];
  logic [31:0] wb[16];

  bit active = 1'b0;
  bit had_done = 1'b0;
  int ek, ew, es, el, e_idx;
  bit e_eq, e_gt;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // FIFO model: present head words, pop on ready.
  always @(negedge clk) begin
    ifc.a_valid = a_en && qa.size() > 0;
    ifc.a_data  = (qa.size() > 0) ? qa[0] : 32'h0;
    ifc.b_valid = b_en && qb.size() > 0;
    ifc.b_data  = (qb.size() > 0) ? qb[0] : 32'h0;
    #1;
    if (ifc.a_ready === 1'b1) begin
      if (qa.size() > 0) void'(qa.pop_front());
      pops_a++;
    end
    if (ifc.b_ready === 1'b1) begin
      if (qb.size() > 0) void'(qb.pop_front());
      pops_b++;
    end
  end

  // Byte-string reference: clamp, scan for first differing byte.
  task automatic model(input int len);
    logic [7:0] ba, bb;
    el = (len > 64) ? 64 : len;
    ew = (el + 3) / 4;
    e_eq = 1'b1;
    e_idx = el;
    e_gt = 1'b0;
    for (int i = 0; i < el; i++) begin
      ba = 8'(wa[i/4] >> (8*(3 - i%4)));
      bb = 8'(wb[i/4] >> (8*(3 - i%4)));
      if (e_eq && ba != bb) begin
        e_eq = 1'b0;
        e_idx = i;
        e_gt = ba > bb;
      end
    end
  endtask

  // Per-cycle compare against the timeline implied by the latency rule.
  always @(negedge clk) begin
    int e;
    bit bexp, dexp;
    #3;
    e = cyc;
    chk("ready_pair", int'(ifc.a_ready), int'(ifc.b_ready));
    if (!active) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_equal", int'(equal), 0);
      chk("idle_gt", int'(a_gt_b), 0);
      chk("idle_idx", int'(mismatch_idx), 0);
      chk("idle_ready", int'(ifc.a_ready), 0);
    end else begin
      if (el == 0) begin
        bexp = 1'b0;
        dexp = (e >= ek + 1) || (e < ek && had_done);
      end else begin
        bexp = (e >= ek) && (e <= ek + 2*ew + es - 1);
        dexp = (e >= ek + 2*ew + es + 1) || (e < ek && had_done);
      end
      chk("busy", int'(busy), int'(bexp));
      chk("done", int'(done), int'(dexp));
      if (dexp && e >= ek) begin
        chk("equal", int'(equal), int'(e_eq));
        chk("mismatch_idx", int'(mismatch_idx), e_idx);
        chk("a_gt_b", int'(a_gt_b), int'(e_gt));
      end
    end
  end

  task automatic start(input int len, input int stall);
    model(len);
    qa.delete();
    qb.delete();
    for (int i = 0; i < ew; i++) begin
      qa.push_back(wa[i]);
      qb.push_back(wb[i]);
    end
    @(posedge clk);
    #2;
    pops_a = 0;
    pops_b = 0;
    es = stall;
    ek = cyc + 1;
    had_done = active;
    active = 1'b1;
    go = 1'b1;
    length = LW'(len);
    if (stall > 0) b_en = 1'b0;
    @(posedge clk);
    #2;
    go = 1'b0;
    length = LW'($urandom);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #2;
      b_en = 1'b1;
    end
  endtask

  task automatic finish_run(output int lat);
    int t;
    t = 0;
    lat = -1;
    while (t < 200) begin
      @(negedge clk);
      #4;
      if (done) begin
        lat = cyc - ek;
        break;
      end
      t++;
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done");
    end
    chk("pops_a", pops_a, ew);
    chk("pops_b", pops_b, ew);
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int pos;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // T1: equal 8-byte strings
    wa[0] = 32'h48454C4C; wa[1] = 32'h4F212121;
    wb[0] = 32'h48454C4C; wb[1] = 32'h4F212121;
    start(8, 0);
    finish_run(lat);
    chk("t1_lat", lat, 5);
    chk("t1_eq", int'(equal), 1);
    chk("t1_idx", int'(mismatch_idx), 8);
    chk("t1_gt", int'(a_gt_b), 0);

    // T2: mismatch at byte 5, trailing bytes differ but ignored
    wa[0] = 32'h61626364; wa[1] = 32'h6566AAAA;
    wb[0] = 32'h61626364; wb[1] = 32'h6567BBBB;
    start(6, 0);
    finish_run(lat);
    chk("t2_lat", lat, 5);
    chk("t2_eq", int'(equal), 0);
    chk("t2_idx", int'(mismatch_idx), 5);
    chk("t2_gt", int'(a_gt_b), 0);

    // T3: early mismatch, full drain of 3 words
    wa[0] = 32'h415A0000; wa[1] = 32'h11111111; wa[2] = 32'h22222222;
    wb[0] = 32'h41420000; wb[1] = 32'h11111100; wb[2] = 32'h33333333;
    start(12, 0);
    finish_run(lat);
    chk("t3_lat", lat, 7);
    chk("t3_pops", pops_a, 3);
    chk("t3_idx", int'(mismatch_idx), 1);
    chk("t3_gt", int'(a_gt_b), 1);

    // T4: B stalls 3 cycles
    wa[0] = 32'hDEADBEEF; wb[0] = 32'hDEADBEEF;
    start(4, 3);
    finish_run(lat);
    chk("t4_lat", lat, 6);
    chk("t4_eq", int'(equal), 1);

    // T5: zero length, then clamped length
    start(0, 0);
    finish_run(lat);
    chk("t5a_lat", lat, 1);
    chk("t5a_eq", int'(equal), 1);
    chk("t5a_idx", int'(mismatch_idx), 0);
    for (int i = 0; i < 16; i++) begin
      wa[i] = $urandom;
      wb[i] = wa[i];
    end
    start(100, 0);
    finish_run(lat);
    chk("t5b_pops_a", pops_a, 16);
    chk("t5b_pops_b", pops_b, 16);
    chk("t5b_lat", lat, 33);
    chk("t5b_idx", int'(mismatch_idx), 64);

    // T6: reset during COMPARE of word 1 of 4
    start(16, 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    active = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_eq", int'(equal), 0);
    chk("t6_ready", int'(ifc.a_ready), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    wa[0] = 32'h01020304; wb[0] = 32'h01020305;
    start(4, 0);
    finish_run(lat);
    chk("t6_lat", lat, 3);
    chk("t6_idx", int'(mismatch_idx), 3);
    chk("t6_gt", int'(a_gt_b), 0);

    // Random strings, lengths and start stalls
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) begin
        wa[i] = $urandom;
        wb[i] = wa[i];
      end
      for (int f = 0; f < 2; f++) begin
        if ($urandom_range(0, 1) == 0) begin
          pos = $urandom_range(0, 63);
          wb[pos/4] = wb[pos/4] ^
            (32'($urandom_range(1, 255)) << (8*(3 - pos%4)));
        end
      end
      start($urandom_range(0, 100), $urandom_range(0, 3));
      finish_run(lat);
    end

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
